// File: rtl/s298_seq_ctrl_if.sv
// s298_seq_ctrl_if: host/core-side bundle of the s298 sequencing controller.
//
// Handshake: start is a request that the controller accepts on a rising clk
// edge only while it is idle (busy=0 and done=0); while busy or done is high,
// start is ignored. done is a one-cycle completion strobe raised after the
// scan-unload finishes. cyc_cnt and sig hold their values until the next
// accepted start.
interface s298_seq_ctrl_if #(
    parameter int SW  = 14,
    parameter int CW  = 16,
    parameter int PIW = 3,
    parameter int POW = 6
);
    logic           start;
    logic [CW-1:0]  cycles;
    logic [PIW-1:0] pi_vec;
    logic           scan_in;
    logic           scan_out;
    logic [PIW-1:0] core_pi;
    logic [SW-1:0]  core_ps;
    logic [SW-1:0]  core_ns;
    logic [POW-1:0] core_po;
    logic           busy;
    logic           done;
    logic [CW-1:0]  cyc_cnt;
    logic [15:0]    sig;
    logic [2:0]     dbg_state;

    // Host plus combinational core side.
    modport master (
        output start, cycles, pi_vec, scan_in, core_ns, core_po,
        input  scan_out, core_pi, core_ps, busy, done, cyc_cnt, sig, dbg_state
    );

    // Controller side.
    modport slave (
        input  start, cycles, pi_vec, scan_in, core_ns, core_po,
        output scan_out, core_pi, core_ps, busy, done, cyc_cnt, sig, dbg_state
    );
endinterface

// File: rtl/s298_seq_ctrl.sv
// s298_seq_ctrl: owns the 14-bit state register of the combinational s298
// core. A run scan-loads the state MSB first, applies 'cycles' functional
// clocks with latched primary inputs, then scan-unloads MSB first.
// Optional feature macro: S298_SEQ_SIGNATURE_EN enables a 16-bit MISR over
// {core_po, core_ns[9:0]} during RUN; without it sig reads 16'h0000.
module s298_seq_ctrl #(
    parameter int SW  = 14,
    parameter int CW  = 16,
    parameter int PIW = 3,
    parameter int POW = 6
) (
    input logic           clk,
    input logic           rst,
    s298_seq_ctrl_if.slave bus
);
    localparam int BW = $clog2(SW + 1);
    localparam logic [BW-1:0] BIT_LAST = BW'(SW - 1);

    localparam logic [2:0] ST_IDLE      = 3'd0;
    localparam logic [2:0] ST_SHIFT_IN  = 3'd1;
    localparam logic [2:0] ST_RUN       = 3'd2;
    localparam logic [2:0] ST_SHIFT_OUT = 3'd3;
    localparam logic [2:0] ST_DONE      = 3'd4;

    logic [2:0]     fsm;
    logic [SW-1:0]  state;
    logic [BW-1:0]  bit_cnt;
    logic [CW-1:0]  cyc_cnt;
    logic [CW-1:0]  cyc_lat;
    logic [CW-1:0]  cyc_nxt;
    logic [PIW-1:0] pi_lat;

    assign cyc_nxt = cyc_cnt + 1'b1;

    // Sequencer: scan-in, functional clocks, scan-out, completion strobe.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fsm     <= ST_IDLE;
            state   <= '0;
            bit_cnt <= '0;
            cyc_cnt <= '0;
            cyc_lat <= '0;
            pi_lat  <= '0;
        end else begin
            case (fsm)
                ST_IDLE: begin
                    if (bus.start) begin
                        cyc_lat <= bus.cycles;
                        pi_lat  <= bus.pi_vec;
                        cyc_cnt <= '0;
                        bit_cnt <= '0;
                        fsm     <= ST_SHIFT_IN;
                    end
                end
                ST_SHIFT_IN: begin
                    state <= {state[SW-2:0], bus.scan_in};
                    if (bit_cnt == BIT_LAST) begin
                        bit_cnt <= '0;
                        fsm     <= (cyc_lat == '0) ? ST_SHIFT_OUT : ST_RUN;
                    end else begin
                        bit_cnt <= bit_cnt + 1'b1;
                    end
                end
                ST_RUN: begin
                    // Exactly cyc_lat core updates before unloading.
                    state   <= bus.core_ns;
                    cyc_cnt <= cyc_nxt;
                    if (cyc_nxt == cyc_lat) begin
                        bit_cnt <= '0;
                        fsm     <= ST_SHIFT_OUT;
                    end
                end
                ST_SHIFT_OUT: begin
                    state <= {state[SW-2:0], 1'b0};
                    if (bit_cnt == BIT_LAST) begin
                        bit_cnt <= '0;
                        fsm     <= ST_DONE;
                    end else begin
                        bit_cnt <= bit_cnt + 1'b1;
                    end
                end
                ST_DONE: begin
                    fsm <= ST_IDLE;
                end
                default: begin
                    fsm <= ST_IDLE;
                end
            endcase
        end
    end

`ifdef S298_SEQ_SIGNATURE_EN
    logic [15:0] sig;

    // MISR compacts next-state and primary outputs on every functional clock.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sig <= '0;
        end else if (fsm == ST_IDLE && bus.start) begin
            sig <= '0;
        end else if (fsm == ST_RUN) begin
            sig <= {sig[14:0], 1'b0} ^ (sig[15] ? 16'h100B : 16'h0000)
                   ^ {bus.core_po, bus.core_ns[9:0]};
        end
    end

    assign bus.sig = sig;
`else
    assign bus.sig = 16'h0000;
`endif

    assign bus.scan_out  = state[SW-1];
    assign bus.core_ps   = state;
    assign bus.core_pi   = (fsm == ST_RUN) ? pi_lat : '0;
    assign bus.busy      = (fsm == ST_SHIFT_IN) || (fsm == ST_RUN) || (fsm == ST_SHIFT_OUT);
    assign bus.done      = (fsm == ST_DONE);
    assign bus.cyc_cnt   = cyc_cnt;
    assign bus.dbg_state = fsm;
endmodule

// File: tb/tb_s298_seq_ctrl.sv
// tb_s298_seq_ctrl: directed runs against a small core stub; expectations are
// queued at issue time and checked when the controller strobes done.
module tb_s298_seq_ctrl;
    localparam int SW = 14;
    localparam int CW = 16;
    localparam int W  = 79;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    s298_seq_ctrl_if bus ();

    s298_seq_ctrl dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Core stub: 0 = increment, 1 = constant 1, 2 = xor with core_pi.
    logic [1:0] core_mode;
    always_comb begin
        bus.core_po = '0;
        case (core_mode)
            2'd1:    bus.core_ns = 14'h0001;
            2'd2:    bus.core_ns = bus.core_ps ^ {11'b0, bus.core_pi};
            default: bus.core_ns = bus.core_ps + 14'd1;
        endcase
    end

    int n_vec = 0;
    int n_err = 0;
    int cyc_no = 0;
    int acc_cyc = 0;
    int done_cyc = 0;

    always @(posedge clk) cyc_no <= cyc_no + 1;

    // Expected entry: {unload[14], cyc_cnt[16], sig[16], busy_len[16], done_lat[16], sig_chk}
    logic [W-1:0] exp_q[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // ---------------- scoreboard monitor ----------------
    int            busy_cnt;
    logic [SW-1:0] cap;
    logic          prev_busy;
    logic          prev_done;
    logic [W-1:0]  e;

    always @(negedge clk) begin
        if (rst) begin
            busy_cnt  = 0;
            cap       = '0;
            prev_busy = 1'b0;
            prev_done = 1'b0;
        end else begin
            if (prev_done) chk("done_pulse", {31'b0, bus.done}, 32'd0);
            if (bus.busy) begin
                busy_cnt = prev_busy ? busy_cnt + 1 : 1;
                cap      = {cap[SW-2:0], bus.scan_out};
            end
            if (bus.done) begin
                done_cyc = cyc_no;
                if (exp_q.size() == 0) begin
                    chk("unexpected_done", 32'd1, 32'd0);
                end else begin
                    e = exp_q.pop_front();
                    chk("unload", {18'b0, cap}, {18'b0, e[78:65]});
                    chk("cyc_cnt", {16'b0, bus.cyc_cnt}, {16'b0, e[64:49]});
                    if (e[0]) chk("sig", {16'b0, bus.sig}, {16'b0, e[48:33]});
                    chk("busy_len", busy_cnt, {16'b0, e[32:17]});
                    chk("done_lat", cyc_no - acc_cyc, {16'b0, e[16:1]});
                end
            end
            prev_busy = bus.busy;
            prev_done = bus.done;
        end
    end

    // ---------------- driver tasks ----------------
    task automatic issue(input logic [SW-1:0] load, input logic [CW-1:0] cyc,
                         input logic [2:0] pi, input logic [1:0] mode,
                         input logic [SW-1:0] exp_unload,
                         input logic sig_chk, input logic [15:0] exp_sig);
        logic        idle;
        logic        ok;
        logic [15:0] e_sig;
        logic        e_chk;
        logic [15:0] len;
        ok = 1'b0;
`ifdef S298_SEQ_SIGNATURE_EN
        e_sig = exp_sig;
        e_chk = sig_chk;
`else
        e_sig = 16'h0000;
        e_chk = 1'b1;
`endif
        len = 16'(2 * SW + int'(cyc));
        @(negedge clk);
        exp_q.push_back({exp_unload, cyc, e_sig, len, len, e_chk});
        core_mode    = mode;
        bus.cycles   = cyc;
        bus.pi_vec   = pi;
        bus.start    = 1'b1;
        for (int i = 0; i < 2000; i++) begin
            idle = !bus.busy && !bus.done;
            @(posedge clk);
            #1;
            if (idle) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
        if (!ok) begin
            chk("accept_timeout", 32'd0, 32'd1);
            bus.start = 1'b0;
            void'(exp_q.pop_back());
            return;
        end
        acc_cyc    = cyc_no;
        bus.start  = 1'b0;
        bus.cycles = ~cyc;
        bus.pi_vec = ~pi;
        for (int i = SW - 1; i >= 0; i--) begin
            bus.scan_in = load[i];
            @(posedge clk);
            #1;
        end
        bus.scan_in = 1'b0;
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 5000 && exp_q.size() != 0; i++) @(negedge clk);
        if (exp_q.size() != 0) begin
            chk("drain_timeout", exp_q.size(), 32'd0);
            exp_q.delete();
        end
        repeat (2) @(negedge clk);
    endtask

    // ---------------- stimulus ----------------
    logic [SW-1:0] ld;

    initial begin
        bus.start   = 1'b0;
        bus.cycles  = 16'd5;
        bus.pi_vec  = 3'b111;
        bus.scan_in = 1'b1;
        core_mode   = 2'd0;
        repeat (3) @(negedge clk);
        chk("rst_busy", {31'b0, bus.busy}, 32'd0);
        chk("rst_done", {31'b0, bus.done}, 32'd0);
        chk("rst_scan_out", {31'b0, bus.scan_out}, 32'd0);
        chk("rst_core_ps", {18'b0, bus.core_ps}, 32'd0);
        chk("rst_cyc_cnt", {16'b0, bus.cyc_cnt}, 32'd0);
        chk("rst_sig", {16'b0, bus.sig}, 32'd0);
        rst = 1'b0;
        @(negedge clk);
        chk("idle_core_pi", {29'b0, bus.core_pi}, 32'd0);
        chk("idle_busy", {31'b0, bus.busy}, 32'd0);

        // Pure scan load/unload, no functional clocks.
        issue(14'h2A5A, 16'd0, 3'b000, 2'd0, 14'h2A5A, 1'b0, 16'h0000);
        wait_idle();
        // Increment stub: 0x0010 + 5 updates; MISR over 0x11..0x15.
        issue(14'h0010, 16'd5, 3'b000, 2'd0, 14'h0015, 1'b1, 16'h01F1);
        wait_idle();
        // State register wraps through 0x3FFF -> 0x0000.
        issue(14'h3FFE, 16'd3, 3'b000, 2'd0, 14'h0001, 1'b0, 16'h0000);
        wait_idle();
        // Latched pi drives the core only during RUN: xor 5 three times.
        issue(14'h1234, 16'd3, 3'b101, 2'd2, 14'h1231, 1'b0, 16'h0000);
        wait_idle();
        // Constant next state 1 twice: signature 1 then 2^1.
        issue(14'h3FFF, 16'd2, 3'b000, 2'd1, 14'h0001, 1'b1, 16'h0003);
        wait_idle();
        // Longer run.
        issue(14'h0000, 16'd200, 3'b000, 2'd0, 14'h00C8, 1'b0, 16'h0000);
        wait_idle();

        // Reset after five shifts of a load: everything clears immediately.
        ld = 14'h2A5A;
        @(negedge clk);
        bus.start = 1'b1;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        for (int i = SW - 1; i >= SW - 5; i--) begin
            bus.scan_in = ld[i];
            @(posedge clk);
            #1;
        end
        @(negedge clk);
        chk("pre_rst_busy", {31'b0, bus.busy}, 32'd1);
        rst = 1'b1;
        #1;
        chk("arst_busy", {31'b0, bus.busy}, 32'd0);
        chk("arst_scan_out", {31'b0, bus.scan_out}, 32'd0);
        chk("arst_core_ps", {18'b0, bus.core_ps}, 32'd0);
        chk("arst_done", {31'b0, bus.done}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        issue(14'h2A5A, 16'd0, 3'b000, 2'd0, 14'h2A5A, 1'b0, 16'h0000);
        wait_idle();

        // Start pulsed in RUN, then held through DONE with other cycles.
        issue(14'h0100, 16'd4, 3'b000, 2'd0, 14'h0104, 1'b0, 16'h0000);
        @(negedge clk);
        bus.cycles = 16'd9;
        bus.start  = 1'b1;
        @(negedge clk);
        bus.start  = 1'b0;
        issue(14'h0AAA, 16'd9, 3'b111, 2'd0, 14'h0AB3, 1'b0, 16'h0000);
        chk("restart_edge", acc_cyc, done_cyc + 2);
        wait_idle();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
